// File: rtl/round_robin_arbiter2to1.sv
// round_robin_arbiter2to1
//
// Purpose:
//   Two-requester round-robin arbiter that sits directly upstream of a 2-to-1
//   multiplexer. It hands the mux path to one requester at a time. Ties go to
//   the requester that was not served last. A requester holding the grant is
//   preempted after MAX_HOLD consecutive cycles in which the other side is also
//   requesting, so a waiting requester never waits more than MAX_HOLD cycles.
//   Every output comes straight from a flop, so the mux select cannot glitch.
//
// Parameters:
//   MAX_HOLD    - maximum consecutive contested cycles one requester keeps the
//                 grant (legal range 1..2**COUNT_WIDTH)
//   COUNT_WIDTH - width of the internal hold counter
//
// Ports:
//   clock        in   system clock; all state changes on its rising edge
//   reset        in   synchronous active-high reset
//   request[1:0] in   request[n]=1 means requester n wants the mux path
//   grant[1:0]   out  one-hot or zero; grant[n]=1 means requester n owns the path
//   selection    out  mux select; 0 picks input 0, 1 picks input 1
//   grant_valid  out  grant[0] | grant[1]
//   grant_change out  one-cycle pulse in the first cycle of every new grant

module round_robin_arbiter2to1 #(
  parameter int MAX_HOLD    = 4,
  parameter int COUNT_WIDTH = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] request,
  output logic [1:0] grant,
  output logic       selection,
  output logic       grant_valid,
  output logic       grant_change
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arbState_e;

  // Counter value at which a contested holder loses the grant on the next edge.
  localparam logic [COUNT_WIDTH-1:0] HOLD_LAST = COUNT_WIDTH'(MAX_HOLD - 1);

  arbState_e              state_q, state_d;
  logic [COUNT_WIDTH-1:0] holdCount_q, holdCount_d;
  logic                   lastServed_q, lastServed_d;
  logic [1:0]             grant_q, grant_d;
  logic                   selection_q, selection_d;
  logic                   grantValid_q, grantValid_d;
  logic                   grantChange_q, grantChange_d;
  logic                   enterGrant;

  // Next-state logic. From IDLE the lone requester wins, and a tie goes to the
  // requester that was not served last. While a grant is held, the holder keeps
  // it until it drops its request (the path passes straight to the other side
  // if that side is waiting) or until the other side has been waiting long
  // enough that the hold counter reaches its limit.
  always_comb begin
    state_d      = state_q;
    holdCount_d  = holdCount_q;
    lastServed_d = lastServed_q;

    case (state_q)
      IDLE: begin
        case (request)
          2'b01:   state_d = GNT0;
          2'b10:   state_d = GNT1;
          2'b11:   state_d = lastServed_q ? GNT0 : GNT1;
          default: state_d = IDLE;
        endcase
      end

      GNT0: begin
        if (!request[0]) begin
          state_d = request[1] ? GNT1 : IDLE;
        end else if (request[1]) begin
          if (holdCount_q == HOLD_LAST) begin
            state_d = GNT1;
          end else begin
            holdCount_d = holdCount_q + COUNT_WIDTH'(1);
          end
        end else begin
          holdCount_d = '0;
        end
      end

      GNT1: begin
        if (!request[1]) begin
          state_d = request[0] ? GNT0 : IDLE;
        end else if (request[0]) begin
          if (holdCount_q == HOLD_LAST) begin
            state_d = GNT0;
          end else begin
            holdCount_d = holdCount_q + COUNT_WIDTH'(1);
          end
        end else begin
          holdCount_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    // A new grant always starts a fresh hold window and records its owner.
    if (enterGrant) begin
      holdCount_d  = '0;
      lastServed_d = (state_d == GNT1);
    end
  end

  // A new grant begins when the next state is a grant state other than the
  // current one. This covers entry from IDLE and the direct GNT0<->GNT1 handoff.
  assign enterGrant = (state_d != state_q) && (state_d != IDLE);

  // Output values for the next cycle. They come from the next state so that the
  // registered outputs line up with the state register. selection changes only
  // when a new grant starts and keeps its last value through IDLE.
  always_comb begin
    grant_d       = {state_d == GNT1, state_d == GNT0};
    grantValid_d  = (state_d != IDLE);
    grantChange_d = enterGrant;
    selection_d   = selection_q;
    if (enterGrant) begin
      selection_d = (state_d == GNT1);
    end
  end

  // State and output registers. Reset abandons any grant at once with no pulse.
  // It sets lastServed to 1 so that requester 0 wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      holdCount_q   <= '0;
      lastServed_q  <= 1'b1;
      grant_q       <= 2'b00;
      selection_q   <= 1'b0;
      grantValid_q  <= 1'b0;
      grantChange_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      holdCount_q   <= holdCount_d;
      lastServed_q  <= lastServed_d;
      grant_q       <= grant_d;
      selection_q   <= selection_d;
      grantValid_q  <= grantValid_d;
      grantChange_q <= grantChange_d;
    end
  end

  assign grant        = grant_q;
  assign selection    = selection_q;
  assign grant_valid  = grantValid_q;
  assign grant_change = grantChange_q;

endmodule

// File: doc/round_robin_arbiter2to1.md
Name: round_robin_arbiter2to1

Overview:
- Two-requester round-robin arbiter with bounded hold time.
- Sits directly upstream of the 2-to-1 multiplexer: its `selection` output drives the mux select, and its `grant` outputs tell each source when its data is on the mux output.
- Guarantees fairness, a glitch-free registered select, and a bounded wait for the non-granted requester.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one requester keeps the grant while the other is requesting; legal range 1..2^COUNT_WIDTH.
- COUNT_WIDTH, 3, width of the internal hold counter.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
- request  input  2  request[n]=1 means requester n wants the mux path.
- grant  output  2  one-hot or zero; grant[n]=1 means requester n owns the path this cycle.
- selection  output  1  mux select; 0 selects input_signal[0], 1 selects input_signal[1].
- grant_valid  output  1  equals grant[0]|grant[1], registered.
- grant_change  output  1  one-cycle pulse in the first cycle of any new grant, including from IDLE.

Behaviour:
- All outputs are registered. Latency is one cycle: request sampled at edge k affects grant/selection after edge k.
- Reset (reset=1 at an edge) forces:
  - state=IDLE, grant=2'b00, selection=0, grant_valid=0, grant_change=0.
  - hold_count=0, last_served=1, so requester 0 wins the first tie.
  - Reset mid-grant aborts the grant immediately at that edge, with no pulse.
- States: IDLE (grant=00), GNT0 (grant=01, selection=0), GNT1 (grant=10, selection=1).
- selection holds its last value in IDLE and changes only on entry to GNT0/GNT1; it never toggles without a grant change.
- IDLE:
  - request=00 -> stay.
  - request=01 -> GNT0.
  - request=10 -> GNT1.
  - request=11 -> GNT of the requester != last_served.
- GNTn, with other = 1-n:
  - request[n]=0 and request[other]=1 -> GNTother directly, no idle bubble.
  - request[n]=0 and request[other]=0 -> IDLE.
  - request[n]=1, request[other]=1 and hold_count==MAX_HOLD-1 -> preempt to GNTother.
  - Otherwise stay; hold_count increments only while request[other]=1, saturating at MAX_HOLD-1.
  - hold_count clears to 0 while request[other]=0.
- On every entry to GNT0/GNT1:
  - hold_count=0.
  - last_served=n of the new grant.
  - grant_change=1 for exactly that cycle.
- grant is never 2'b11. Transitions GNT0<->GNT1 are single-edge, with no cycle where grant=00.
- MAX_HOLD=1: with both requesting continuously, the grant alternates every cycle.
- Worst-case wait for a continuously requesting input after the other is granted: MAX_HOLD cycles.

Test Plan:
- Reset: hold reset=1 for 2 cycles with request=11 -> grant=00, selection=0, grant_valid=0, grant_change=0; release, then after 1 edge grant=01, selection=0, grant_change=1.
- Single requester: request=10 from IDLE -> next cycle grant=10, selection=1; hold 10 cycles -> grant stays 10, no preemption, grant_change pulses once only.
- Fair preemption (MAX_HOLD=4): request=11 continuously from IDLE -> grant pattern 01×4, 10×4, 01×4; selection toggles every 4 cycles; grant_change pulses on cycles 1, 5, 9.
- Release handoff: GNT0 with request=11, then request drops to 10 -> next cycle grant=10 directly with no 00 cycle; then request=00 -> grant=00, selection stays 1.
- Tie after idle: serve requester 1, go IDLE, then request=11 -> grant=01 (last_served=1).
- Reset mid-grant: in GNT1 with hold_count=2, assert reset -> next cycle grant=00, selection=0; deassert with request=11 -> grant=01.
